// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// FSM state encodings and default bus widths.
package mem_stage_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_WBUF_DEPTH = 4;
  localparam int unsigned DEF_CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUS  = 2'd1,
    RD_BUS  = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_fifo.sv
// Posted-store write buffer: synchronous FIFO of (word address, data) pairs
// with occupancy count; pointers wrap naturally because DEPTH is a power of two.
module write_buffer_fifo #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: posts stores into a write buffer and
// stalls the pipeline on loads until the multi-cycle bus returns data.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned WBUF_DEPTH = DEF_WBUF_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [CNT_W-1:0]  wbuf_count,
  output logic              align_err
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] aligned_addr;
  logic [ADDR_W-1:0] wb_head_addr;
  logic [DATA_W-1:0] wb_head_data;
  logic              wb_full;
  logic              wb_empty;
  logic              push;
  logic              pop;
  logic              load_start;
  logic              rd_complete;

  assign aligned_addr = {addr[ADDR_W-1:2], 2'b00};

  // Read wins over a simultaneous write; full is judged on the pre-edge count.
  assign push        = mem_write & ~mem_read & ~wb_full;
  assign load_start  = (state_q == IDLE) & wb_empty & mem_read;
  assign pop         = (state_q == WR_BUS) & bus_ack;
  assign rd_complete = (state_q == RD_BUS) & bus_ack;

  assign stall = rst & ((mem_read & (state_q != RD_DONE)) | (mem_write & wb_full));

  write_buffer_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (WBUF_DEPTH),
    .CNT_W  (CNT_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (aligned_addr),
    .push_data (write_data),
    .head_addr (wb_head_addr),
    .head_data (wb_head_data),
    .full      (wb_full),
    .empty     (wb_empty),
    .count     (wbuf_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      read_data <= '0;
      align_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_start)  rd_addr_q <= aligned_addr;
      if (rd_complete) read_data <= bus_rdata;
      if ((push | load_start) && is_misaligned(addr[1:0])) align_err <= 1'b1;
    end
  end

  // Bus outputs depend only on state and registered/buffered values, so they
  // stay stable for the whole request and fall to zero once reset lands.
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      IDLE: begin
        if (!wb_empty)     state_d = WR_BUS;
        else if (mem_read) state_d = RD_BUS;
      end
      WR_BUS: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = wb_head_addr;
        bus_wdata = wb_head_data;
        if (bus_ack) state_d = IDLE;
      end
      RD_BUS: begin
        bus_req  = 1'b1;
        bus_addr = rd_addr_q;
        if (bus_ack) state_d = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a program-order memory model predicts
// bus transactions and load results; a monitor compares as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          stall;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic [CW-1:0] wbuf_count;
  logic          align_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .WBUF_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .wbuf_count (wbuf_count),
    .align_err  (align_err)
  );

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } bus_txn_t;

  bus_txn_t    exp_bus[$];
  logic [31:0] exp_load[$];
  logic [31:0] ref_mem[bit [31:0]];
  logic [31:0] slave_mem[bit [31:0]];
  bit          exp_align = 1'b0;
  bit          auto_ack = 1'b0;
  int          ack_credit = 0;
  bit          stray_ack = 1'b0;
  int          wait_cnt = 0;
  int          n_rd_txn = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus slave: acks automatically after a random wait, or on credits/stray requests.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (stray_ack) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
        stray_ack = 1'b0;
      end else if (bus_req === 1'b1 && rst === 1'b1 &&
                   (auto_ack ? (wait_cnt == 0) : (ack_credit > 0))) begin
        bus_ack = 1'b1;
        if (bus_we) slave_mem[bus_addr] = bus_wdata;
        else bus_rdata = slave_mem.exists(bus_addr) ? slave_mem[bus_addr] : init_word(bus_addr);
        if (!auto_ack) ack_credit--;
        wait_cnt = $urandom_range(0, 3);
      end else if (bus_req === 1'b1 && wait_cnt > 0) begin
        wait_cnt--;
      end
    end
  end

  // Monitor: compares completed bus transactions and load results against the queues.
  bus_txn_t    mon_t;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (prev_req && bus_req && !prev_ack) begin
        check("bus_addr_stable", bus_addr, prev_addr);
        check("bus_we_stable", 32'(bus_we), 32'(prev_we));
        check("bus_wdata_stable", bus_wdata, prev_wdata);
      end
      if (bus_req && bus_ack) begin
        if (exp_bus.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bus_txn: got we=%0b addr=%h, expected no transaction", bus_we, bus_addr);
        end else begin
          mon_t = exp_bus.pop_front();
          check("bus_we", 32'(bus_we), 32'(mon_t.we));
          check("bus_addr", bus_addr, mon_t.a);
          if (mon_t.we) check("bus_wdata", bus_wdata, mon_t.d);
          if (!bus_we) n_rd_txn++;
        end
      end
      if (mem_read && !stall) begin
        if (exp_load.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_load_done: got read_data=%h, expected no completion", read_data);
        end else begin
          check("load_data", read_data, exp_load.pop_front());
        end
      end
    end
    prev_req   = bus_req & rst;
    prev_ack   = bus_ack;
    prev_we    = bus_we;
    prev_addr  = bus_addr;
    prev_wdata = bus_wdata;
  end

  task automatic do_reset();
    rst = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    addr = '0;
    write_data = '0;
    auto_ack = 1'b0;
    ack_credit = 0;
    stray_ack = 1'b0;
    step();
    step();
    exp_bus.delete();
    exp_load.delete();
    ref_mem.delete();
    slave_mem.delete();
    exp_align = 1'b0;
    rst = 1'b1;
  endtask

  // One pipeline instruction: record expectations, hold until it retires.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] al;
    int n;
    al = {a[31:2], 2'b00};
    n = 0;
    if (rd) begin
      exp_bus.push_back('{we: 1'b0, a: al, d: 32'h0});
      exp_load.push_back(ref_read(al));
      if (a[1:0] != 2'b00) exp_align = 1'b1;
    end else if (wr) begin
      exp_bus.push_back('{we: 1'b1, a: al, d: d});
      ref_mem[al] = d;
      if (a[1:0] != 2'b00) exp_align = 1'b1;
    end
    mem_read = rd;
    mem_write = wr;
    addr = a;
    write_data = d;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 200) begin
        check("issue_timeout", 32'(n), 32'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    auto_ack = 1'b1;
    while ((wbuf_count != '0 || bus_req) && n < 500) begin
      step();
      n++;
    end
    step();
    step();
    check("drain_done", 32'(n < 500), 32'(1));
    check("bus_queue_empty", 32'(exp_bus.size()), 32'(0));
    check("load_queue_empty", 32'(exp_load.size()), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n0;
    logic [31:0] a;
    int r;

    // Reset state, with requests held high to show stall is forced low.
    rst = 1'b0;
    mem_read = 1'b1;
    mem_write = 1'b1;
    addr = 32'h13;
    step();
    step();
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_bus_req", 32'(bus_req), 32'(0));
    check("rst_bus_we", 32'(bus_we), 32'(0));
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_wbuf_count", 32'(wbuf_count), 32'(0));
    check("rst_align_err", 32'(align_err), 32'(0));
    step();
    do_reset();

    // Single load at 0x10, ack in cycle 3.
    ref_mem[32'h10] = 32'hDEADBEEF;
    slave_mem[32'h10] = 32'hDEADBEEF;
    exp_bus.push_back('{we: 1'b0, a: 32'h10, d: 32'h0});
    exp_load.push_back(32'hDEADBEEF);
    n0 = n_rd_txn;
    mem_read = 1'b1;
    addr = 32'h10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("load_stall_c%0d", c), 32'(stall), 32'(c < 4));
      if (c == 1) begin
        check("load_bus_req", 32'(bus_req), 32'(1));
        check("load_bus_we", 32'(bus_we), 32'(0));
        check("load_bus_addr", bus_addr, 32'h10);
      end
      if (c == 2) ack_credit = 1;
      if (c == 4) check("load_read_data", read_data, 32'hDEADBEEF);
      @(posedge clk);
      #1;
    end
    mem_read = 1'b0;
    ack_credit = 2;
    repeat (4) step();
    check("load_single_bus_read", 32'(n_rd_txn - n0), 32'(1));
    ack_credit = 0;

    // Reset while a read is in flight; late acks must not touch read_data.
    mem_read = 1'b1;
    addr = 32'h40;
    step();
    step();
    @(negedge clk);
    check("midrd_bus_req", 32'(bus_req), 32'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrd_stall_in_reset", 32'(stall), 32'(0));
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrd_bus_req_dropped", 32'(bus_req), 32'(0));
    check("midrd_read_data_cleared", read_data, 32'h0);
    check("midrd_stall_low", 32'(stall), 32'(0));
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_read = 1'b0;
    step();
    @(negedge clk);
    check("midrd_late_ack_ignored", read_data, 32'h0);
    check("midrd_idle_no_req", 32'(bus_req), 32'(0));
    step();
    do_reset();

    // Fill the buffer with four stores, then a fifth stalls until a pop.
    for (int i = 0; i < 4; i++) begin
      mem_write = 1'b1;
      addr = 32'(i * 4);
      write_data = 32'(i + 1);
      exp_bus.push_back('{we: 1'b1, a: 32'(i * 4), d: 32'(i + 1)});
      @(negedge clk);
      check($sformatf("fill_stall_%0d", i), 32'(stall), 32'(0));
      @(posedge clk);
      #1;
    end
    addr = 32'h10;
    write_data = 32'd5;
    exp_bus.push_back('{we: 1'b1, a: 32'h10, d: 32'd5});
    @(negedge clk);
    check("full_count", 32'(wbuf_count), 32'(4));
    check("full_stall", 32'(stall), 32'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_stall_hold", 32'(stall), 32'(1));
    ack_credit = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_stall_during_pop", 32'(stall), 32'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_after_pop_count", 32'(wbuf_count), 32'(3));
    check("full_after_pop_stall", 32'(stall), 32'(0));
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    check("fifth_enqueued_count", 32'(wbuf_count), 32'(4));
    drain();
    do_reset();

    // Simultaneous push and pop at count 2.
    for (int i = 0; i < 2; i++) begin
      mem_write = 1'b1;
      addr = 32'h80 + 32'(i * 4);
      write_data = 32'h11 * 32'(i + 1);
      exp_bus.push_back('{we: 1'b1, a: 32'h80 + 32'(i * 4), d: 32'h11 * 32'(i + 1)});
      step();
    end
    mem_write = 1'b0;
    step();
    @(negedge clk);
    check("pp_count_before", 32'(wbuf_count), 32'(2));
    ack_credit = 1;
    @(posedge clk);
    #1;
    mem_write = 1'b1;
    addr = 32'h88;
    write_data = 32'h33;
    exp_bus.push_back('{we: 1'b1, a: 32'h88, d: 32'h33});
    @(negedge clk);
    check("pp_stall", 32'(stall), 32'(0));
    check("pp_head_at_pop", bus_addr, 32'h80);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    check("pp_count_after", 32'(wbuf_count), 32'(2));
    step();
    @(negedge clk);
    check("pp_head_advanced_addr", bus_addr, 32'h84);
    check("pp_head_advanced_data", bus_wdata, 32'h22);
    drain();
    do_reset();

    // Store then dependent load, and sticky misalignment.
    auto_ack = 1'b1;
    issue(1'b0, 1'b1, 32'h20, 32'h55);
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("align_clear_before", 32'(align_err), 32'(0));
    step();
    issue(1'b1, 1'b0, 32'h13, 32'h0);
    @(negedge clk);
    check("align_set", 32'(align_err), 32'(1));
    step();
    issue(1'b0, 1'b1, 32'h24, 32'h77);
    issue(1'b1, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    check("align_sticky", 32'(align_err), 32'(1));
    step();
    drain();
    do_reset();
    @(negedge clk);
    check("align_cleared_by_reset", 32'(align_err), 32'(0));
    step();

    // Randomized instruction stream against the program-order model.
    auto_ack = 1'b1;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if (r <= 2) step();
      else if (r <= 5) issue(1'b0, 1'b1, a, $urandom);
      else if (r <= 8) issue(1'b1, 1'b0, a, 32'h0);
      else issue(1'b1, 1'b1, a, $urandom);
    end
    drain();
    @(negedge clk);
    check("random_align_err", 32'(align_err), 32'(exp_align));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage data-memory controller between the EX/MEM pipeline register and a multi-cycle external data bus. It replaces the single-cycle data memory.
- Stores are posted into a small write buffer, so the pipeline continues without waiting.
- Loads stall the whole pipeline until bus data returns.
- The returned load data is registered for capture by MEM/WB.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WBUF_DEPTH, 4, write-buffer entries (power of two, at least 2).
- CNT_W, 3, width of wbuf_count (log2(WBUF_DEPTH)+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- addr  in  ADDR_W  ALU result (byte address).
- write_data  in  DATA_W  store data.
- read_data  out  DATA_W  registered load data, toward MEM/WB.
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  word-aligned bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_ack  in  1  one-cycle completion pulse.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- wbuf_count  out  CNT_W  current write-buffer occupancy.
- align_err  out  1  sticky misalignment flag.

Behaviour:
- Reset (rst=0 at an edge):
  - state goes to IDLE; buffer is emptied (pointers and count 0); pending writes are discarded.
  - read_data=0, align_err=0.
  - bus_req, bus_we, bus_addr and bus_wdata are 0.
  - stall is forced to 0 while rst=0.
  - Reset applies mid-transaction too: an in-flight bus_req drops the next cycle, and a late bus_ack is ignored.
- FSM states and transitions:
  - IDLE:
    - buffer non-empty -> WR_BUS (drained writes take priority, which preserves read-after-write order).
    - else mem_read=1 -> RD_BUS, latching aligned addr into rd_addr.
    - else stay.
  - WR_BUS: bus_req=1, bus_we=1, bus_addr/bus_wdata = buffer head. On bus_ack: pop head -> IDLE.
  - RD_BUS: bus_req=1, bus_we=0, bus_addr=rd_addr. On bus_ack: read_data<=bus_rdata -> RD_DONE.
  - RD_DONE: one cycle, unconditional -> IDLE. The pipeline advances at the end of this cycle; the still-present mem_read is not re-issued.
- Bus rules:
  - Address, data and we stay stable from bus_req rise until bus_ack.
  - bus_ack while bus_req=0 is ignored.
- stall = rst & ((mem_read & state!=RD_DONE) | (mem_write & wbuf_full)). It is combinational from state, count and inputs.
- Load latency: a load with empty buffer presented in cycle 0 gives bus_req=1 in cycle 1. With bus_ack in cycle k, the cycle k+1 is RD_DONE with stall=0 and read_data valid.
- Store acceptance:
  - Enqueue when mem_write=1, mem_read=0 and count<WBUF_DEPTH.
  - Full is judged on the pre-edge count; a same-cycle pop does not admit an enqueue.
  - Simultaneous push and pop leaves count unchanged.
- mem_read and mem_write both high: read is served, write is ignored.
- Alignment: addr[1:0] is forced to 0 on the bus. align_err sets on any accepted access with addr[1:0]!=0 and clears only on reset.
- read_data holds its value until the next load completes.
- Buffer pointers wrap modulo WBUF_DEPTH.

Decomposition:
- Shared constants header: FSM state encodings (IDLE=2'd0, WR_BUS=2'd1, RD_BUS=2'd2, RD_DONE=2'd3) and the default bus widths.
- One sub-module, write_buffer_fifo: synchronous FIFO with push/pop, full/empty, count and head outputs, and the same reset.

Test Plan:
- Reset mid-read: assert rst=0 in RD_BUS -> next cycle bus_req=0, stall=0, read_data=0; a bus_ack arriving after reset leaves read_data at 0.
- Single load, empty buffer, addr=0x10: bus_ack after 3 cycles with bus_rdata=0xDEADBEEF -> stall high for 4 cycles, then 1 cycle low with read_data=0xDEADBEEF; exactly one bus read.
- Four back-to-back stores (0x0..0xC, data 1..4), no ack -> stall stays 0, wbuf_count=4. A fifth store -> stall=1 until the first bus_ack; it enqueues on the next edge.
- Store 0x20=0x55 then load 0x20 next cycle -> bus shows write (we=1, 0x20, 0x55) before the read; the load returns bus-supplied data after the write is acked.
- Push and pop in the same cycle at count=2 -> count stays 2; head advances; tail entry correct.
- Load at addr=0x13 -> bus_addr=0x10, align_err=1, and it stays 1 after later aligned accesses until reset.
